// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC predictor: counter encodings,
// per-entry BTB status and elaboration-time helpers.
package npc_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Width-independent part of a BTB entry; tag and target widths follow
    // XLEN, so they live in parameterised arrays beside this struct.
    typedef struct packed {
        logic valid;
        ctr_t ctr;
    } btb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken && (c != CTR_ST)) begin
            r = ctr_t'(c + 2'd1);
        end else if (!taken && (c != CTR_SNT)) begin
            r = ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/npc_btb_array.sv
// Direct-mapped BTB storage: combinational lookup port, synchronous
// read-modify-write update port, synchronous clear.
module npc_btb_array
    import npc_pkg::*;
#(
    parameter int  XLEN    = 32,
    parameter int  ENTRIES = 16,
    localparam int IDX     = clog2(ENTRIES),
    localparam int TAG_W   = XLEN - IDX - 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX-1:0]   i_lk_idx,
    input  logic [TAG_W-1:0] i_lk_tag,
    output logic             o_lk_hit,
    output logic             o_lk_taken,
    output logic [XLEN-1:0]  o_lk_target,
    input  logic             i_upd_en,
    input  logic [IDX-1:0]   i_upd_idx,
    input  logic [TAG_W-1:0] i_upd_tag,
    input  logic             i_upd_taken,
    input  logic [XLEN-1:0]  i_upd_target
);

    btb_state_t       r_state  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];

    btb_state_t w_lk_state;
    btb_state_t w_upd_state;
    logic       w_lk_hit;
    logic       w_upd_hit;

    assign w_lk_state  = r_state[i_lk_idx];
    assign w_lk_hit    = w_lk_state.valid && (r_tag[i_lk_idx] == i_lk_tag);
    assign o_lk_hit    = w_lk_hit;
    assign o_lk_taken  = w_lk_hit && (w_lk_state.ctr >= CTR_WT);
    assign o_lk_target = r_target[i_lk_idx];

    assign w_upd_state = r_state[i_upd_idx];
    assign w_upd_hit   = w_upd_state.valid && (r_tag[i_upd_idx] == i_upd_tag);

    // Lookup reads the old entry; a same-cycle update lands on the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i]  <= '{valid: 1'b0, ctr: CTR_WNT};
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (i_upd_en) begin
            if (w_upd_hit) begin
                r_state[i_upd_idx] <= '{valid: 1'b1,
                                        ctr: ctr_next(w_upd_state.ctr, i_upd_taken)};
                if (i_upd_taken) begin
                    r_target[i_upd_idx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                r_state[i_upd_idx]  <= '{valid: 1'b1, ctr: CTR_WT};
                r_tag[i_upd_idx]    <= i_upd_tag;
                r_target[i_upd_idx] <= i_upd_target;
            end
        end
    end

endmodule

// File: rtl/npc_predict.sv
// Fetch PC register with BTB prediction, exception/ERET redirect, ID-stage
// mispredict recovery and optional delay-slot pending redirect.
module npc_predict
    import npc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR  = '0,
    parameter bit              DELAY_SLOT  = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_exc_req,
    input  logic            i_eret_req,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_id_resolve_valid,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic            i_id_taken,
    input  logic [XLEN-1:0] i_id_target,
    input  logic            i_id_pred_taken,
    input  logic [XLEN-1:0] i_id_pred_target,
    output logic [XLEN-1:0] o_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    output logic            o_flush_if
);

    localparam int              IDX       = clog2(BTB_ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    // Not-taken recovery skips the delay slot, which already issued.
    localparam logic [XLEN-1:0] FALL_STEP = DELAY_SLOT ? XLEN'(8) : XLEN'(4);

    logic [XLEN-1:0] r_pc;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;

    logic [XLEN-1:0] w_pc_next;
    logic            w_pend_valid_next;
    logic [XLEN-1:0] w_pend_target_next;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_fix_pc;
    logic [XLEN-1:0] w_pred_target;
    logic            w_mispredict;
    logic            w_lk_hit;
    logic            w_lk_taken;
    logic [XLEN-1:0] w_lk_target;
    logic            w_upd_en;

    npc_btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_lk_idx     (r_pc[IDX+1:2]),
        .i_lk_tag     (r_pc[XLEN-1:IDX+2]),
        .o_lk_hit     (w_lk_hit),
        .o_lk_taken   (w_lk_taken),
        .o_lk_target  (w_lk_target),
        .i_upd_en     (w_upd_en),
        .i_upd_idx    (i_id_pc[IDX+1:2]),
        .i_upd_tag    (i_id_pc[XLEN-1:IDX+2]),
        .i_upd_taken  (i_id_taken),
        .i_upd_target (i_id_target)
    );

    assign w_pc_seq      = r_pc + PC_STEP;
    assign w_pred_target = w_lk_hit ? w_lk_target : w_pc_seq;

    assign w_mispredict = i_id_resolve_valid && !i_stall &&
                          ((i_id_taken != i_id_pred_taken) ||
                           (i_id_taken && (i_id_target != i_id_pred_target)));

    assign w_fix_pc = i_id_taken ? i_id_target : (i_id_pc + FALL_STEP);
    assign w_upd_en = i_id_resolve_valid && !i_stall && !i_exc_req;

    always_comb begin
        w_pc_next          = w_pc_seq;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        if (i_exc_req) begin
            w_pc_next         = EXC_VECTOR;
            w_pend_valid_next = 1'b0;
        end else if (i_eret_req) begin
            w_pc_next         = i_epc;
            w_pend_valid_next = 1'b0;
        end else if (w_mispredict) begin
            w_pc_next         = w_fix_pc;
            w_pend_valid_next = 1'b0;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else if (DELAY_SLOT && r_pend_valid) begin
            w_pc_next         = r_pend_target;
            w_pend_valid_next = 1'b0;
        end else if (w_lk_taken) begin
            if (DELAY_SLOT) begin
                // Fetch the delay slot now, remember where to go after it.
                w_pend_valid_next  = 1'b1;
                w_pend_target_next = w_pred_target;
            end else begin
                w_pc_next = w_pred_target;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
        end
    end

    assign o_pc          = r_pc;
    assign o_pred_taken  = w_lk_taken;
    assign o_pred_target = w_pred_target;
    assign o_flush_if    = !i_rst &&
                           (i_exc_req || i_eret_req || (w_mispredict && !DELAY_SLOT));

endmodule

// File: tb/tb_npc_predict.sv
// Bench for npc_predict: a delay-slot/4-entry instance and a no-delay-slot/
// 16-entry instance share stimulus and are checked against an array model.
module tb_npc_predict;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, exc_req, eret_req, rv, id_taken, id_pred_taken;
    logic [31:0] epc, id_pc, id_target, id_pred_target;
    logic [31:0] pc_o  [2];
    logic [31:0] ptg_o [2];
    logic        ptk_o [2];
    logic        fl_o  [2];

    npc_predict #(.XLEN(32), .BTB_ENTRIES(4), .RESET_PC(32'h0040_0000),
                  .EXC_VECTOR(32'h0000_0180), .DELAY_SLOT(1'b1)) u_dut_ds (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_exc_req(exc_req),
        .i_eret_req(eret_req), .i_epc(epc), .i_id_resolve_valid(rv),
        .i_id_pc(id_pc), .i_id_taken(id_taken), .i_id_target(id_target),
        .i_id_pred_taken(id_pred_taken), .i_id_pred_target(id_pred_target),
        .o_pc(pc_o[0]), .o_pred_taken(ptk_o[0]), .o_pred_target(ptg_o[0]),
        .o_flush_if(fl_o[0]));

    npc_predict #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0040_0000),
                  .EXC_VECTOR(32'h0000_0080), .DELAY_SLOT(1'b0)) u_dut_nd (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_exc_req(exc_req),
        .i_eret_req(eret_req), .i_epc(epc), .i_id_resolve_valid(rv),
        .i_id_pc(id_pc), .i_id_taken(id_taken), .i_id_target(id_target),
        .i_id_pred_taken(id_pred_taken), .i_id_pred_target(id_pred_target),
        .o_pc(pc_o[1]), .o_pred_taken(ptk_o[1]), .o_pred_target(ptg_o[1]),
        .o_flush_if(fl_o[1]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_live;
    logic [31:0] m_pc  [2];
    logic [31:0] m_pt  [2];
    bit          m_pv  [2];
    bit          m_val [2][16];
    logic [31:0] m_tag [2][16];
    logic [31:0] m_tgt [2][16];
    int          m_ctr [2][16];

    function automatic int nent(input int d);  return (d == 0) ? 4 : 16; endfunction
    function automatic int ibits(input int d); return (d == 0) ? 2 : 4;  endfunction
    function automatic bit has_ds(input int d); return d == 0; endfunction
    function automatic logic [31:0] evec(input int d);
        return (d == 0) ? 32'h180 : 32'h80;
    endfunction
    function automatic string nm(input int d); return (d == 0) ? "ds" : "nd"; endfunction

    function automatic int slot(input int d, input logic [31:0] a);
        logic [31:0] q;
        q = (a >> 2) % 32'(nent(d));
        return int'(q);
    endfunction

    function automatic bit m_hit(input int d, input logic [31:0] a);
        int s;
        s = slot(d, a);
        return m_val[d][s] && (m_tag[d][s] == (a >> (2 + ibits(d))));
    endfunction

    function automatic bit m_ptk(input int d);
        return m_hit(d, m_pc[d]) && (m_ctr[d][slot(d, m_pc[d])] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input int d);
        return m_hit(d, m_pc[d]) ? m_tgt[d][slot(d, m_pc[d])] : m_pc[d] + 32'd4;
    endfunction

    function automatic bit m_mp();
        return rv && !stall && ((id_taken != id_pred_taken) ||
                                (id_taken && (id_target != id_pred_target)));
    endfunction

    task automatic m_check(input int d);
        bit exp_fl;
        if (!m_live) return;
        exp_fl = !rst && (exc_req || eret_req || (m_mp() && !has_ds(d)));
        chk({nm(d), "_pc"},  pc_o[d],        m_pc[d]);
        chk({nm(d), "_ptk"}, 32'(ptk_o[d]),  32'(m_ptk(d)));
        chk({nm(d), "_ptg"}, ptg_o[d],       m_ptg(d));
        chk({nm(d), "_fl"},  32'(fl_o[d]),   32'(exp_fl));
    endtask

    task automatic m_step(input int d);
        bit          ptk;
        logic [31:0] ptg;
        int          s;
        if (rst) begin
            m_pc[d] = 32'h0040_0000;
            m_pv[d] = 1'b0;
            m_pt[d] = 32'h0;
            for (int i = 0; i < 16; i++) begin
                m_val[d][i] = 1'b0;
                m_ctr[d][i] = 1;
            end
            return;
        end
        ptk = m_ptk(d);
        ptg = m_ptg(d);
        if (exc_req) begin
            m_pc[d] = evec(d); m_pv[d] = 1'b0;
        end else if (eret_req) begin
            m_pc[d] = epc; m_pv[d] = 1'b0;
        end else if (m_mp()) begin
            m_pc[d] = id_taken ? id_target : id_pc + (has_ds(d) ? 32'd8 : 32'd4);
            m_pv[d] = 1'b0;
        end else if (stall) begin
            m_pc[d] = m_pc[d];
        end else if (m_pv[d]) begin
            m_pc[d] = m_pt[d]; m_pv[d] = 1'b0;
        end else if (ptk) begin
            if (has_ds(d)) begin
                m_pv[d] = 1'b1; m_pt[d] = ptg; m_pc[d] = m_pc[d] + 32'd4;
            end else begin
                m_pc[d] = ptg;
            end
        end else begin
            m_pc[d] = m_pc[d] + 32'd4;
        end
        if (rv && !stall && !exc_req) begin
            s = slot(d, id_pc);
            if (m_hit(d, id_pc)) begin
                if (id_taken) begin
                    m_ctr[d][s] = (m_ctr[d][s] == 3) ? 3 : m_ctr[d][s] + 1;
                    m_tgt[d][s] = id_target;
                end else begin
                    m_ctr[d][s] = (m_ctr[d][s] == 0) ? 0 : m_ctr[d][s] - 1;
                end
            end else if (id_taken) begin
                m_val[d][s] = 1'b1;
                m_tag[d][s] = id_pc >> (2 + ibits(d));
                m_tgt[d][s] = id_target;
                m_ctr[d][s] = 2;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) m_check(d);
        for (int d = 0; d < 2; d++) m_step(d);
        if (rst) m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; exc_req = 0; eret_req = 0; rv = 0;
        id_taken = 0; id_pred_taken = 0; epc = '0; id_pc = '0;
        id_target = '0; id_pred_target = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                           input bit ptk, input logic [31:0] ptg);
        rv = 1; id_pc = pc; id_taken = tk; id_target = tg;
        id_pred_taken = ptk; id_pred_target = ptg;
    endtask

    task automatic redirect(input logic [31:0] a);
        idle(); eret_req = 1; epc = a; tick(); idle();
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] tbl [8];
        tbl = '{32'h10, 32'h20, 32'h100, 32'h104, 32'h110, 32'h200,
                32'h0040_0000, 32'hFFFF_FFFC};
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        m_live = 1'b0;
        idle();
        // reset, with an exception request that must not raise flush
        rst = 1; exc_req = 1;
        #1;
        chk("rst_flush_ds", 32'(fl_o[0]), 32'h0);
        chk("rst_flush_nd", 32'(fl_o[1]), 32'h0);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("rst_seq_pc", pc_o[0], 32'h0040_0000 + 32'(4 * k));
            chk("rst_seq_ptk", 32'(ptk_o[0]), 32'h0);
            if (k < 3) tick();
        end

        // first resolution of 0x100 -> 0x200 is a mispredict
        resolve(32'h100, 1, 32'h200, 0, 32'h104);
        #1;
        chk("mp1_flush_ds", 32'(fl_o[0]), 32'h0);
        chk("mp1_flush_nd", 32'(fl_o[1]), 32'h1);
        tick();
        chk("mp1_pc_ds", pc_o[0], 32'h200);
        chk("mp1_pc_nd", pc_o[1], 32'h200);
        redirect(32'h100);
        chk("refetch_ptk", 32'(ptk_o[0]), 32'h1);
        chk("refetch_ptg", ptg_o[0], 32'h200);
        tick();
        chk("delay_slot_pc", pc_o[0], 32'h104);
        chk("nd_pred_pc", pc_o[1], 32'h200);
        tick();
        chk("pend_target_pc", pc_o[0], 32'h200);

        // WT entry resolved not taken
        resolve(32'h100, 0, 32'h200, 1, 32'h200);
        #1;
        chk("nt_flush_nd", 32'(fl_o[1]), 32'h1);
        chk("nt_flush_ds", 32'(fl_o[0]), 32'h0);
        tick();
        chk("nt_pc_nd", pc_o[1], 32'h104);
        chk("nt_pc_ds", pc_o[0], 32'h108);
        idle();
        #1;
        chk("nt_flush_drop", 32'(fl_o[1]), 32'h0);
        redirect(32'h100);
        chk("wnt_ptk_nd", 32'(ptk_o[1]), 32'h0);
        chk("wnt_ptg_nd", ptg_o[1], 32'h200);

        // retrain to WT, then stall while a redirect is pending
        resolve(32'h100, 1, 32'h200, 1, 32'h200);
        tick();
        redirect(32'h100);
        chk("wt_again_ptk", 32'(ptk_o[0]), 32'h1);
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", pc_o[0], 32'h104);
        end
        stall = 0;
        tick();
        chk("stall_release_pc", pc_o[0], 32'h200);

        // exc + eret + mispredict together while a redirect is pending
        redirect(32'h100);
        tick();
        exc_req = 1; eret_req = 1; epc = 32'h300;
        resolve(32'h20, 1, 32'h300, 0, 32'h0);
        #1;
        chk("exc_flush_ds", 32'(fl_o[0]), 32'h1);
        chk("exc_flush_nd", 32'(fl_o[1]), 32'h1);
        tick();
        chk("exc_pc_ds", pc_o[0], 32'h180);
        chk("exc_pc_nd", pc_o[1], 32'h80);
        idle();
        tick();
        chk("exc_pend_clr", pc_o[0], 32'h184);
        redirect(32'h20);
        chk("exc_no_wr_ptk", 32'(ptk_o[0]), 32'h0);
        chk("exc_no_wr_ptg", ptg_o[0], 32'h24);

        // index aliasing in the 4-entry BTB
        resolve(32'h10, 1, 32'h80, 0, 32'h0);
        tick();
        resolve(32'h20, 1, 32'h90, 0, 32'h0);
        tick();
        redirect(32'h10);
        chk("evict_ptk_ds", 32'(ptk_o[0]), 32'h0);
        chk("evict_ptg_ds", ptg_o[0], 32'h14);
        chk("noalias_ptk_nd", 32'(ptk_o[1]), 32'h1);
        chk("noalias_ptg_nd", ptg_o[1], 32'h80);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            exc_req  = ($urandom_range(0, 24) == 0);
            eret_req = ($urandom_range(0, 19) == 0);
            epc      = pick();
            rv       = $urandom_range(0, 1) != 0;
            id_pc    = pick();
            id_taken = $urandom_range(0, 1) != 0;
            id_target = pick();
            id_pred_taken = $urandom_range(0, 1) != 0;
            id_pred_target = ($urandom_range(0, 1) != 0) ? id_target : pick();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/npc_predict.md
# npc_predict

Parametrised next-PC unit for the five-stage MIPS pipeline. It owns the fetch PC register and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It handles exception entry, ERET return, ID-stage branch resolution and an optional architectural delay slot. It sits between the IF stage (PC, prediction out) and the ID stage (resolution in), with exception and ERET requests coming from the CP0 path.

## Interface
- XLEN, 32: address width.
- BTB_ENTRIES, 16: BTB depth; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h0000_0000: exception entry address.
- DELAY_SLOT, 1: 1 = MIPS delay-slot semantics; 0 = no delay slot, flush on redirect.

Ports:
- clk  in  1  system clock; one clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  IF/ID hold; freezes the PC, pending-target state and BTB updates.
- exc_req  in  1  take an exception; overrides stall.
- eret_req  in  1  return from exception.
- epc  in  XLEN  return address for ERET, already forwarded.
- id_resolve_valid  in  1  ID holds a resolved control-transfer instruction.
- id_pc  in  XLEN  PC of that instruction.
- id_taken  in  1  actual direction.
- id_target  in  XLEN  actual target.
- id_pred_taken  in  1  prediction carried down with the instruction.
- id_pred_target  in  XLEN  predicted target carried down with the instruction.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  combinational BTB prediction for `pc`.
- pred_target  out  XLEN  combinational predicted target for `pc`.
- flush_if  out  1  squash the instruction currently in IF.

## Operation
- The next-PC is chosen by this priority: rst, exc_req, eret_req, mispredict, stall, pending redirect, BTB-predicted taken, sequential.
  - rst: RESET_PC.
  - exc_req: EXC_VECTOR.
  - eret_req: epc.
  - mispredict: the correct PC.
  - stall: hold the current PC.
  - pending redirect: pend_target.
  - BTB-predicted taken: the predicted target when DELAY_SLOT=0; pc+4 when DELAY_SLOT=1.
  - sequential: pc+4.
- Mispredict = id_resolve_valid & !stall & ((id_taken != id_pred_taken) | (id_taken & id_target != id_pred_target)).
- Correct PC on mispredict:
  - id_taken = 1: id_target.
  - id_taken = 0, DELAY_SLOT=0: id_pc+4.
  - id_taken = 0, DELAY_SLOT=1: id_pc+8.
- Pending redirect (DELAY_SLOT=1 only):
  - When pc is predicted taken and the cycle is not stalled, set pend_valid and pend_target = pred_target.
  - The next unstalled cycle consumes it, which fetches the delay slot first and then the target.
  - exc_req, eret_req and mispredict clear pend_valid.
- flush_if is asserted for exc_req, for eret_req, and for mispredict when DELAY_SLOT=0. It is 0 otherwise, including mispredict with DELAY_SLOT=1.
- BTB addressing:
  - index = addr[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - tag = addr[XLEN-1:IDX+2].
  - Each entry holds valid, tag, target (XLEN) and a 2-bit counter.
- Prediction: hit = valid & tag match on `pc`. pred_taken = hit & ctr[1]. pred_target = entry target on a hit, pc+4 otherwise.
- BTB update happens when id_resolve_valid & !stall & !exc_req:
  - hit on id_pc: counter saturating +1 if taken, -1 if not taken; target rewritten when taken.
  - miss and taken: allocate the entry (overwrite), counter = 2'b10.
  - miss and not taken: no change.
- All PC arithmetic is modulo 2^XLEN; wrap-around is permitted without error.

## Timing
- Reset values:
  - pc = RESET_PC.
  - pend_valid = 0, pend_target = 0.
  - every BTB valid bit = 0, every counter = 2'b01.
  - flush_if = 0 while rst is asserted.
  - pred_taken = 0 on the first cycle after reset.
- Redirect latency: exc, eret and mispredict each take effect on `pc` one edge after the request.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update entry; the update is visible on the next cycle.
- Simultaneous exc_req and eret_req: exc wins. Simultaneous exc_req and mispredict: exc wins, and the BTB is not updated.
- rst asserted mid-operation discards the pending state and all BTB contents on that edge.
- stall=1 with no exc_req leaves pc, pend_* and the BTB unchanged; eret_req and mispredict are held off by the upstream stall.

## Structure
- Shared package `npc_pkg`:
  - counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - function `clog2`.
  - typedef for the BTB entry struct.
- Sub-module `npc_btb_array`:
  - register array with one combinational read port (lookup) and one synchronous write port (update).
  - synchronous clear on rst.
- Top level contains the next-PC priority mux, the pending-redirect register and the mispredict comparator.

## Test plan
- Reset with RESET_PC=0x0040_0000, no stimulus for 4 cycles → pc = 0x400000, 0x400004, 0x400008, 0x40000C; pred_taken = 0.
- DELAY_SLOT=1; branch at 0x100 resolved taken to 0x200, then re-fetched → first resolution is a mispredict and the following pc is 0x200; on re-fetch, pred_taken = 1 and pc goes 0x100, 0x104, 0x200.
- DELAY_SLOT=0; BTB entry for 0x100 in state WT, resolved not taken → counter becomes WNT, next pc = 0x104, flush_if = 1 for one cycle.
- exc_req and eret_req in the same cycle with epc=0x300 → next pc = EXC_VECTOR, flush_if = 1, pend_valid = 0, no BTB write.
- stall held 3 cycles while a prediction is pending → pc frozen; after release, pc = pend_target on the first unstalled edge.
- BTB_ENTRIES=4: taken branches at 0x10 and 0x20 both index 0 → the second evicts the first; lookup at 0x10 then misses with pred_target = 0x14.
